// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : MEM-stage initiator for a word-wide data memory. Accepts one
//                load/store per handshake, runs read-modify-write for SB/SH,
//                returns sign/zero-extended load data and reports misaligned,
//                illegal-width and timeout errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_cause,
    output logic        mem_writeEn,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_storeVal,
    input  logic [31:0] mem_loadVal,
    input  logic        mem_data_ready
);

    localparam int              CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      c_cause_none = 2'b00;
    localparam logic [1:0]      c_cause_mis  = 2'b01;
    localparam logic [1:0]      c_cause_ill  = 2'b10;
    localparam logic [1:0]      c_cause_tmo  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_WR_WAIT = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Latched request fields (only what later states actually need)
    logic               r_store;
    logic [1:0]         r_lane;
    logic [2:0]         r_func3;
    logic [15:0]        r_wdata;
    logic [CNT_W-1:0]   r_cnt;

    // Registered outputs
    logic               r_req_ready;
    logic               r_resp_valid;
    logic [31:0]        r_resp_rdata;
    logic               r_resp_err;
    logic [1:0]         r_resp_cause;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_storeval;

    // Next-state values for the registered outputs
    logic               w_accept;
    logic               w_illegal;
    logic               w_misaligned;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_mem_we_nxt;
    logic [31:0]        w_mem_addr_nxt;
    logic [31:0]        w_mem_storeval_nxt;
    logic [31:0]        w_resp_rdata_nxt;
    logic               w_resp_err_nxt;
    logic [1:0]         w_resp_cause_nxt;

    // Pick the addressed lane of a loaded word and extend it to 32 bits
    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
        logic [7:0]  v_b;
        logic [15:0] v_h;
        logic [31:0] v_res;
        v_b = word[{lane, 3'b000} +: 8];
        v_h = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   v_res = f3[2] ? {24'h0, v_b} : {{24{v_b[7]}}, v_b};
            2'b01:   v_res = f3[2] ? {16'h0, v_h} : {{16{v_h[15]}}, v_h};
            default: v_res = word;
        endcase
        return v_res;
    endfunction

    // Overlay the store byte/half onto the word read back from memory
    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [2:0]  f3,
                                            input logic [15:0] wd);
        logic [31:0] v_res;
        v_res = word;
        if (f3[1:0] == 2'b00) begin
            v_res[{lane, 3'b000} +: 8] = wd[7:0];
        end else if (lane[1]) begin
            v_res[31:16] = wd;
        end else begin
            v_res[15:0] = wd;
        end
        return v_res;
    endfunction

    assign w_accept     = (r_state == S_IDLE) && req_valid;
    // Reserved widths, or unsigned variants used with a store
    assign w_illegal    = (req_func3 == 3'b011) || (req_func3 == 3'b110) ||
                          (req_func3 == 3'b111) || (req_store && req_func3[2]);
    assign w_misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    // Next-state and next-output decode; every output is registered from here
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_mem_we_nxt       = 1'b0;
        w_mem_addr_nxt     = r_mem_addr;
        w_mem_storeval_nxt = r_mem_storeval;
        w_resp_rdata_nxt   = 32'h0;
        w_resp_err_nxt     = 1'b0;
        w_resp_cause_nxt   = c_cause_none;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_illegal) begin
                        w_state_nxt      = S_RESP;
                        w_resp_err_nxt   = 1'b1;
                        w_resp_cause_nxt = c_cause_ill;
                    end else if (w_misaligned) begin
                        w_state_nxt      = S_RESP;
                        w_resp_err_nxt   = 1'b1;
                        w_resp_cause_nxt = c_cause_mis;
                    end else begin
                        w_mem_addr_nxt = {req_addr[31:2], 2'b00};
                        if (req_store && (req_func3[1:0] == 2'b10)) begin
                            w_state_nxt        = S_WR;
                            w_mem_we_nxt       = 1'b1;
                            w_mem_storeval_nxt = req_wdata;
                        end else begin
                            w_state_nxt = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                w_state_nxt = S_RD_WAIT;
                w_cnt_nxt   = '0;
            end
            S_RD_WAIT: begin
                if (mem_data_ready) begin
                    if (r_store) begin
                        w_state_nxt        = S_WR;
                        w_mem_we_nxt       = 1'b1;
                        w_mem_storeval_nxt = f_merge(mem_loadVal, r_lane, r_func3, r_wdata);
                    end else begin
                        w_state_nxt      = S_RESP;
                        w_resp_rdata_nxt = f_extract(mem_loadVal, r_lane, r_func3);
                    end
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt      = S_RESP;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_cause_nxt = c_cause_tmo;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WR: begin
                w_state_nxt = S_WR_WAIT;
                w_cnt_nxt   = '0;
            end
            S_WR_WAIT: begin
                if (mem_data_ready) begin
                    w_state_nxt = S_RESP;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt      = S_RESP;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_cause_nxt = c_cause_tmo;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= 32'h0;
            r_resp_err     <= 1'b0;
            r_resp_cause   <= c_cause_none;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= 32'h0;
            r_mem_storeval <= 32'h0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_req_ready    <= (w_state_nxt == S_IDLE);
            r_resp_valid   <= (w_state_nxt == S_RESP);
            r_resp_rdata   <= w_resp_rdata_nxt;
            r_resp_err     <= w_resp_err_nxt;
            r_resp_cause   <= w_resp_cause_nxt;
            r_mem_we       <= w_mem_we_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_mem_storeval <= w_mem_storeval_nxt;
        end
    end

    // Capture request fields at the accepting edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_store <= 1'b0;
            r_lane  <= 2'b00;
            r_func3 <= 3'b000;
            r_wdata <= 16'h0;
        end else if (w_accept) begin
            r_store <= req_store;
            r_lane  <= req_addr[1:0];
            r_func3 <= req_func3;
            r_wdata <= req_wdata[15:0];
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_err     = r_resp_err;
    assign resp_cause   = r_resp_cause;
    assign mem_writeEn  = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_func3    = 3'b010;
    assign mem_storeVal = r_mem_storeval;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Scoreboard bench for load_store_unit with a word memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TMO = 16;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_cause;
    logic        mem_writeEn;
    logic [31:0] mem_addr;
    logic [2:0]  mem_func3;
    logic [31:0] mem_storeVal;
    logic [31:0] mem_loadVal;
    logic        mem_data_ready;

    logic        ready_en;
    logic [31:0] mem [0:63];
    int          wr_cnt;
    int          n_chk;
    int          n_fail;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
        int          lat;
        time         t_acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_lat;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_addr       (req_addr),
        .req_func3      (req_func3),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .resp_cause     (resp_cause),
        .mem_writeEn    (mem_writeEn),
        .mem_addr       (mem_addr),
        .mem_func3      (mem_func3),
        .mem_storeVal   (mem_storeVal),
        .mem_loadVal    (mem_loadVal),
        .mem_data_ready (mem_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on clock edge, ready gated by bench
    assign mem_loadVal    = mem[mem_addr[7:2]];
    assign mem_data_ready = ready_en;

    always @(posedge clk) begin
        if (mem_writeEn) begin
            mem[mem_addr[7:2]] <= mem_storeVal;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pop expected response whenever the DUT presents one
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                mon_e   = sb.pop_front();
                mon_lat = int'(($time - mon_e.t_acc + 5) / 10);
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_err", {31'h0, resp_err}, {31'h0, mon_e.err});
                chk("resp_cause", {30'h0, resp_cause}, {30'h0, mon_e.cause});
                chk("latency", 32'(mon_lat), 32'(mon_e.lat));
                chk("mem_func3", {29'h0, mem_func3}, 32'h2);
                chk("mem_addr_lsb", {30'h0, mem_addr[1:0]}, 32'h0);
            end
        end
    end

    // Issue one request and push its expected response at the accept edge
    task automatic issue(input logic st, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, input logic [31:0] erd, input logic ee,
                         input logic [1:0] ec, input int elat);
        int   g;
        exp_t e;
        @(negedge clk);
        req_store = st;
        req_addr  = a;
        req_func3 = f3;
        req_wdata = wd;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.rdata = erd;
            e.err   = ee;
            e.cause = ec;
            e.lat   = elat;
            e.t_acc = $time;
            sb.push_back(e);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    int w0;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        wr_cnt    = 0;
        ready_en  = 1'b1;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_addr  = 32'h0;
        req_func3 = 3'b000;
        req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_writeEn}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_storeval", mem_storeVal, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'h0);
        chk("rst_cause", {30'h0, resp_cause}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Word store then load back
        issue(1'b1, 32'h10, F_W, 32'h8000_00F0, 32'h0, 1'b0, 2'b00, 3);
        issue(1'b0, 32'h10, F_W, 32'h0, 32'h8000_00F0, 1'b0, 2'b00, 3);
        drain();

        // Lane extraction with sign/zero extension
        issue(1'b1, 32'h20, F_W,  32'h1234_ABCD, 32'h0, 1'b0, 2'b00, 3);
        issue(1'b0, 32'h21, F_B,  32'h0, 32'hFFFF_FFAB, 1'b0, 2'b00, 3);
        issue(1'b0, 32'h21, F_BU, 32'h0, 32'h0000_00AB, 1'b0, 2'b00, 3);
        issue(1'b0, 32'h22, F_H,  32'h0, 32'h0000_1234, 1'b0, 2'b00, 3);
        issue(1'b0, 32'h20, F_H,  32'h0, 32'hFFFF_ABCD, 1'b0, 2'b00, 3);
        issue(1'b0, 32'h20, F_HU, 32'h0, 32'h0000_ABCD, 1'b0, 2'b00, 3);
        issue(1'b0, 32'h20, F_B,  32'h0, 32'hFFFF_FFCD, 1'b0, 2'b00, 3);
        drain();

        // Read-modify-write byte and half stores
        issue(1'b1, 32'h20, F_W, 32'h1122_3344, 32'h0, 1'b0, 2'b00, 3);
        drain();
        w0 = wr_cnt;
        issue(1'b1, 32'h23, F_B, 32'hFFFF_FF5A, 32'h0, 1'b0, 2'b00, 5);
        drain();
        chk("sb_write_pulses", 32'(wr_cnt - w0), 32'h1);
        chk("sb_merged_word", mem[8], 32'h5A22_3344);
        issue(1'b1, 32'h22, F_H, 32'h1234_BEEF, 32'h0, 1'b0, 2'b00, 5);
        issue(1'b0, 32'h20, F_W, 32'h0, 32'hBEEF_3344, 1'b0, 2'b00, 3);
        drain();

        // Error paths: no memory write, single-cycle latency
        w0 = wr_cnt;
        issue(1'b0, 32'h06, F_W, 32'h0, 32'h0, 1'b1, 2'b01, 1);
        issue(1'b1, 32'h03, F_H, 32'hFFFF, 32'h0, 1'b1, 2'b01, 1);
        issue(1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, 2'b10, 1);
        issue(1'b1, 32'h10, F_BU, 32'h0, 32'h0, 1'b1, 2'b10, 1);
        issue(1'b0, 32'h03, 3'b111, 32'h0, 32'h0, 1'b1, 2'b10, 1);
        drain();
        chk("err_no_write", 32'(wr_cnt - w0), 32'h0);

        // Timeout while waiting for read data
        ready_en = 1'b0;
        w0 = wr_cnt;
        issue(1'b0, 32'h10, F_W, 32'h0, 32'h0, 1'b1, 2'b11, TMO + 2);
        issue(1'b1, 32'h11, F_B, 32'h77, 32'h0, 1'b1, 2'b11, TMO + 2);
        drain();
        chk("tmo_no_write", 32'(wr_cnt - w0), 32'h0);
        chk("tmo_mem_kept", mem[4], 32'h8000_00F0);
        ready_en = 1'b1;

        // Reset during the write cycle drops the write and the response
        w0 = wr_cnt;
        @(negedge clk);
        req_store = 1'b1;
        req_addr  = 32'h30;
        req_func3 = F_W;
        req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("wr_state_we", {31'h0, mem_writeEn}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_drop_we", {31'h0, mem_writeEn}, 32'h0);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_no_resp", {31'h0, resp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_write", 32'(wr_cnt - w0), 32'h0);
        chk("rst_mem_kept", mem[12], 32'h0);

        // Normal operation resumes after reset
        issue(1'b0, 32'h10, F_W, 32'h0, 32'h8000_00F0, 1'b0, 2'b00, 3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
